// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, writeback select, halt tracking and cache-stall watchdog.
// Optional retire/stall performance counters are enabled by defining MEM_WB_PERF_EN.
module mem_wb_stage #(
   parameter int STALL_LIMIT = 64,
   parameter int SC_W        = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ValidM,
   input  logic [15:0] XOutM,
   input  logic [15:0] MemOutM,
   input  logic        DC_Stall,
   input  logic        RegWriteM,
   input  logic        MemToRegM,
   input  logic [2:0]  WriteRegM,
   input  logic        HaltM,
   input  logic        ErrM,
   output logic        RegWriteW,
   output logic [2:0]  WriteRegW,
   output logic [15:0] WriteDataW,
   output logic        ValidW,
   output logic        Halted,
   output logic        Err
`ifdef MEM_WB_PERF_EN
   ,
   output logic [31:0] RetireCnt,
   output logic [31:0] StallCnt
`endif
);
   typedef enum logic {RUN, HALTED} state_t;
   state_t state;
   logic [15:0] x_q, mem_q;
   logic m2r_q;
   logic [SC_W-1:0] stall_cnt;
   logic cap, wd_fire;
   assign cap = ValidM & ~DC_Stall & (state == RUN);
   // fires on the edge where the counter reaches the limit (and on every later stalled edge)
   assign wd_fire = DC_Stall & (stall_cnt >= SC_W'(STALL_LIMIT - 1));
   assign WriteDataW = m2r_q ? mem_q : x_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= RUN;
         x_q       <= '0;
         mem_q     <= '0;
         m2r_q     <= 1'b0;
         WriteRegW <= '0;
         ValidW    <= 1'b0;
         RegWriteW <= 1'b0;
         Halted    <= 1'b0;
         Err       <= 1'b0;
         stall_cnt <= '0;
      end else begin
         ValidW    <= cap;
         RegWriteW <= cap & RegWriteM;
         if (cap) begin
            x_q       <= XOutM;
            mem_q     <= MemOutM;
            m2r_q     <= MemToRegM;
            WriteRegW <= WriteRegM;
         end
         if (cap & HaltM) begin
            state  <= HALTED;
            Halted <= 1'b1;
         end
         stall_cnt <= !DC_Stall ? '0 : (stall_cnt == SC_W'(STALL_LIMIT)) ? stall_cnt : stall_cnt + 1'b1;
         if ((cap & ErrM) | wd_fire) Err <= 1'b1;
      end
`ifdef MEM_WB_PERF_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         RetireCnt <= '0;
         StallCnt  <= '0;
      end else begin
         if (cap) RetireCnt <= RetireCnt + 1'b1;
         if (ValidM & DC_Stall & (state == RUN)) StallCnt <= StallCnt + 1'b1;
      end
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage with STALL_LIMIT=4.
module tb_mem_wb_stage;
   logic clk = 1'b0, rst = 1'b0;
   logic ValidM, DC_Stall, RegWriteM, MemToRegM, HaltM, ErrM;
   logic [15:0] XOutM, MemOutM;
   logic [2:0] WriteRegM;
   logic RegWriteW, ValidW, Halted, Err;
   logic [2:0] WriteRegW;
   logic [15:0] WriteDataW;
   int checks = 0, errors = 0;
`ifdef MEM_WB_PERF_EN
   logic [31:0] RetireCnt, StallCnt;
`endif
   always #5 clk = ~clk;
   mem_wb_stage #(.STALL_LIMIT(4), .SC_W(3)) dut (
      .clk(clk), .rst(rst), .ValidM(ValidM), .XOutM(XOutM), .MemOutM(MemOutM),
      .DC_Stall(DC_Stall), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
      .WriteRegM(WriteRegM), .HaltM(HaltM), .ErrM(ErrM), .RegWriteW(RegWriteW),
      .WriteRegW(WriteRegW), .WriteDataW(WriteDataW), .ValidW(ValidW),
      .Halted(Halted), .Err(Err)
`ifdef MEM_WB_PERF_EN
      , .RetireCnt(RetireCnt), .StallCnt(StallCnt)
`endif
   );
   task automatic drive(input logic v, input logic [15:0] x, m, input logic s, rw, m2r,
                        input logic [2:0] wr, input logic h, e);
      ValidM = v; XOutM = x; MemOutM = m; DC_Stall = s; RegWriteM = rw;
      MemToRegM = m2r; WriteRegM = wr; HaltM = h; ErrM = e;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) rst = 1'b0;
      step();
      rst = 1'b1;
   endtask
   task automatic test_reset();
      drive(0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 7, 0, 0);
      step(); step();
      checks++; if (ValidW !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ValidW); end
      checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", RegWriteW); end
      checks++; if (WriteRegW !== 3'd0) begin errors++; $display("FAIL reset_wreg got %0d exp 0", WriteRegW); end
      checks++; if (WriteDataW !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0000", WriteDataW); end
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", Halted); end
      checks++; if (Err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", Err); end
      rst = 1'b1;
   endtask
   task automatic test_alu();
      drive(1, 16'h1234, 16'h9999, 0, 1, 0, 3, 0, 0);
      step();
      checks++; if (ValidW !== 1'b1) begin errors++; $display("FAIL alu_valid got %b exp 1", ValidW); end
      checks++; if (RegWriteW !== 1'b1) begin errors++; $display("FAIL alu_regwrite got %b exp 1", RegWriteW); end
      checks++; if (WriteRegW !== 3'd3) begin errors++; $display("FAIL alu_wreg got %0d exp 3", WriteRegW); end
      checks++; if (WriteDataW !== 16'h1234) begin errors++; $display("FAIL alu_wdata got %h exp 1234", WriteDataW); end
      drive(0, 16'h0, 16'h0, 0, 1, 1, 0, 0, 0);
      step();
      checks++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0) begin errors++; $display("FAIL alu_bubble got %b%b exp 00", ValidW, RegWriteW); end
      checks++; if (WriteDataW !== 16'h1234 || WriteRegW !== 3'd3) begin errors++; $display("FAIL alu_hold got %h/%0d exp 1234/3", WriteDataW, WriteRegW); end
   endtask
   task automatic test_load_stall();
      drive(1, 16'h5555, 16'hBEEF, 1, 1, 1, 5, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0) begin errors++; $display("FAIL stall_bubble%0d got %b%b exp 00", i, ValidW, RegWriteW); end
         checks++; if (WriteDataW !== 16'h1234) begin errors++; $display("FAIL stall_hold%0d got %h exp 1234", i, WriteDataW); end
      end
      DC_Stall = 1'b0;
      step();
      checks++; if (ValidW !== 1'b1 || RegWriteW !== 1'b1) begin errors++; $display("FAIL load_write got %b%b exp 11", ValidW, RegWriteW); end
      checks++; if (WriteDataW !== 16'hBEEF || WriteRegW !== 3'd5) begin errors++; $display("FAIL load_data got %h/%0d exp beef/5", WriteDataW, WriteRegW); end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      checks++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0) begin errors++; $display("FAIL load_once got %b%b exp 00", ValidW, RegWriteW); end
      checks++; if (Err !== 1'b0) begin errors++; $display("FAIL load_err got %b exp 0", Err); end
   endtask
   task automatic test_watchdog();
      for (int r = 0; r < 3; r++) begin
         DC_Stall = 1'b1;
         step(); step(); step();
         DC_Stall = 1'b0;
         step();
         checks++; if (Err !== 1'b0) begin errors++; $display("FAIL wd_below%0d got %b exp 0", r, Err); end
      end
      DC_Stall = 1'b1;
      step(); step(); step();
      checks++; if (Err !== 1'b0) begin errors++; $display("FAIL wd_edge3 got %b exp 0", Err); end
      step();
      checks++; if (Err !== 1'b1) begin errors++; $display("FAIL wd_edge4 got %b exp 1", Err); end
      DC_Stall = 1'b0;
      step(); step();
      checks++; if (Err !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b exp 1", Err); end
   endtask
   task automatic test_errm();
      drive(1, 16'h1111, 16'h2222, 1, 1, 0, 1, 0, 1);
      step();
      checks++; if (Err !== 1'b0) begin errors++; $display("FAIL errm_stalled got %b exp 0", Err); end
      drive(0, 16'h1111, 16'h2222, 0, 1, 0, 1, 0, 1);
      step();
      checks++; if (Err !== 1'b0) begin errors++; $display("FAIL errm_bubble got %b exp 0", Err); end
      drive(1, 16'h1111, 16'h2222, 0, 1, 0, 1, 0, 1);
      step();
      checks++; if (Err !== 1'b1) begin errors++; $display("FAIL errm_cap got %b exp 1", Err); end
   endtask
   task automatic test_halt();
      drive(1, 16'h0A0A, 16'h0, 0, 1, 0, 2, 1, 0);
      step();
      checks++; if (Halted !== 1'b1 || ValidW !== 1'b1) begin errors++; $display("FAIL halt_retire got %b%b exp 11", Halted, ValidW); end
      checks++; if (RegWriteW !== 1'b1 || WriteDataW !== 16'h0A0A) begin errors++; $display("FAIL halt_write got %b/%h exp 1/0a0a", RegWriteW, WriteDataW); end
      drive(1, 16'h7777, 16'h0, 0, 1, 0, 6, 0, 1);
      step(); step();
      checks++; if (RegWriteW !== 1'b0 || ValidW !== 1'b0) begin errors++; $display("FAIL halt_block got %b%b exp 00", RegWriteW, ValidW); end
      checks++; if (WriteDataW !== 16'h0A0A || WriteRegW !== 3'd2) begin errors++; $display("FAIL halt_hold got %h/%0d exp 0a0a/2", WriteDataW, WriteRegW); end
      checks++; if (Halted !== 1'b1 || Err !== 1'b0) begin errors++; $display("FAIL halt_sticky got %b/%b exp 1/0", Halted, Err); end
      do_reset();
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b exp 0", Halted); end
   endtask
   task automatic test_async_reset();
      drive(1, 16'h4321, 16'h0, 0, 1, 0, 7, 0, 0);
      step();
      drive(1, 16'h0, 16'hCAFE, 1, 1, 1, 4, 0, 0);
      step();
      checks++; if (WriteDataW !== 16'h4321 || WriteRegW !== 3'd7) begin errors++; $display("FAIL ar_pre got %h/%0d exp 4321/7", WriteDataW, WriteRegW); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({ValidW, RegWriteW, WriteRegW, WriteDataW, Halted, Err} !== 23'd0) begin errors++; $display("FAIL ar_clear got %b%b/%0d/%h/%b%b exp all 0", ValidW, RegWriteW, WriteRegW, WriteDataW, Halted, Err); end
      DC_Stall = 1'b0;
      step();
      checks++; if (ValidW !== 1'b0 || WriteDataW !== 16'h0) begin errors++; $display("FAIL ar_hold got %b/%h exp 0/0000", ValidW, WriteDataW); end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
   endtask
`ifdef MEM_WB_PERF_EN
   task automatic test_perf();
      do_reset();
      checks++; if (RetireCnt !== 32'd0 || StallCnt !== 32'd0) begin errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", RetireCnt, StallCnt); end
      drive(1, 16'h1, 16'h0, 0, 1, 0, 1, 0, 0);
      step();
      DC_Stall = 1'b1;
      step(); step(); step();
      DC_Stall = 1'b0;
      step();
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
      step();
      DC_Stall = 1'b0;
      checks++; if (RetireCnt !== 32'd2 || StallCnt !== 32'd3) begin errors++; $display("FAIL perf_count got %0d/%0d exp 2/3", RetireCnt, StallCnt); end
   endtask
`endif
   initial begin
      test_reset();
      test_alu();
      test_load_stall();
      test_watchdog();
      do_reset();
      test_errm();
      do_reset();
      test_halt();
      test_async_reset();
`ifdef MEM_WB_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback-select stage. Sits directly downstream of the memory stage and captures its load data, ALU result and control. It converts data-cache stall cycles into writeback bubbles and drives the register-file write port. It also tracks halt retirement and raises a sticky error flag that includes a cache-stall watchdog.

Parameters:
STALL_LIMIT, 64, maximum consecutive DC_Stall cycles before the watchdog error fires (must be at least 1)
SC_W, 7, width of the stall counter; must satisfy 2^SC_W > STALL_LIMIT

Ports:
clk          input   1   system clock, rising edge
rst          input   1   asynchronous, active-low reset
ValidM       input   1   instruction in MEM is valid (not a bubble)
XOutM        input   16  ALU result / effective address from MEM
MemOutM      input   16  load data from the data cache
DC_Stall     input   1   data cache busy; MEM result not ready this cycle
RegWriteM    input   1   instruction writes the register file
MemToRegM    input   1   select load data (1) or ALU result (0)
WriteRegM    input   3   destination register index
HaltM        input   1   instruction is HALT
ErrM         input   1   error reported by the memory stage
RegWriteW    output  1   register-file write enable
WriteRegW    output  3   register-file write index
WriteDataW   output  16  register-file write data
ValidW       output  1   a real instruction retires this cycle
Halted       output  1   HALT has retired; sticky until reset
Err          output  1   sticky error flag

Behaviour:
- Reset: while rst=0, all registers clear asynchronously. RegWriteW=0, WriteRegW=0, WriteDataW=0, ValidW=0, Halted=0, Err=0, stall counter=0, FSM=RUN.
- Capture condition: cap = ValidM & ~DC_Stall & (state==RUN). Latency is one cycle from MEM to the W outputs.
- When cap=1 at a rising edge:
  - register XOutM, MemOutM, MemToRegM, WriteRegM;
  - ValidW<=1 and RegWriteW<=RegWriteM.
- When cap=0 at a rising edge:
  - ValidW<=0 and RegWriteW<=0 (bubble);
  - data and index registers hold their previous values.
- WriteDataW = registered MemToReg ? registered MemOut : registered XOut. This is a combinational mux of registers only; there is no path from inputs to outputs.
- A DC_Stall cycle always produces a bubble, even if ValidM=1. The MEM stage re-presents the same instruction on the cycle it is released.
- FSM states and transitions:
  - RUN -> HALTED when cap & HaltM. On that edge ValidW<=1, RegWriteW<=RegWriteM, Halted<=1.
  - HALTED is terminal. cap is forced to 0, ValidW=0, RegWriteW=0, and Halted stays 1 until rst=0.
- Watchdog:
  - counter increments on each edge with DC_Stall=1 and clears on each edge with DC_Stall=0;
  - the counter saturates at STALL_LIMIT;
  - reaching STALL_LIMIT sets Err.
- Err is set on the edge where either (cap & ErrM) or the watchdog fires. It is sticky until reset. ErrM on bubble, stalled or post-halt cycles is ignored.
- Err does not by itself stop capture; the top level decides.
- Reset asserted mid-stall or mid-halt returns everything to reset values immediately; no write is committed.
- Inputs with X/Z are not checked here; the memory stage already reports those via ErrM.

Optional Feature:
Macro MEM_WB_PERF_EN.
- Defined: adds outputs RetireCnt[31:0] and StallCnt[31:0].
  - RetireCnt increments on each edge with cap=1.
  - StallCnt increments on each edge with ValidM & DC_Stall & (state==RUN).
  - Both counters wrap modulo 2^32 and reset to 0.
- Not defined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then ValidM=1, RegWriteM=1, MemToRegM=0, XOutM=16'h1234, WriteRegM=3 with DC_Stall=0 -> next cycle ValidW=1, RegWriteW=1, WriteRegW=3, WriteDataW=16'h1234.
- Load: MemToRegM=1, MemOutM=16'hBEEF, DC_Stall=1 for 3 cycles then 0 -> 3 bubble cycles (ValidW=0, RegWriteW=0, WriteDataW unchanged), then exactly one write of 16'hBEEF.
- HaltM=1 with ValidM=1, DC_Stall=0 -> Halted=1 and ValidW=1 the next cycle. A following valid RegWriteM=1 instruction -> RegWriteW stays 0 and Halted stays 1 until rst pulses low.
- STALL_LIMIT=4 with DC_Stall held for 4 edges -> Err=1 after the 4th edge and stays 1 after DC_Stall drops. With STALL_LIMIT=4, 3 stall edges then 1 free edge, repeated -> Err stays 0.
- ErrM=1 while DC_Stall=1 -> Err stays 0. ErrM=1 with cap=1 -> Err=1 on the next edge.
- Assert rst=0 asynchronously (between edges) during a stalled load -> all outputs 0 immediately. With MEM_WB_PERF_EN defined, RetireCnt and StallCnt read 0, then count 2 and 3 over a 2-retire, 3-stall sequence.
